reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer directly downstream of the completion stage.
- Allocates one entry per cycle at dispatch and hands out the ROB tag.
- Accepts completion writes (data, flags and their valid bits) keyed by tag. Serves two operand-lookup ports to the reservation stations.
- Retires the oldest entry in program order once its result is ready.

Parameters:
ROBsize, 32, number of entries
ROBsizeLog, $clog2(ROBsize+1), tag width; tag 0 reserved as "no tag", entries use tags 1..ROBsize
DEST_W, 5, architectural destination register index width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-low reset
flush_i  in  1  discard all entries (mispredict)
alloc_valid_i  in  1  dispatch requests an entry
alloc_dest_i  in  DEST_W  destination register of the instruction
alloc_setsFlags_i  in  1  instruction writes NZCV
alloc_ready_o  out  1  entry available (not full)
alloc_tag_o  out  ROBsizeLog  tag granted when alloc_valid_i & alloc_ready_o
ROBWriteEn_i  in  1  completion write strobe
ROBWriteAddr_i  in  ROBsizeLog  completion tag
ROBWriteData_i  in  70  [63:0] data, [64] data valid, [68:65] flags, [69] flags valid
readTagA_i, readTagB_i  in  ROBsizeLog  operand lookup tags
readValA_o, readValB_o  out  65  [63:0] data, [64] valid
commit_valid_o  out  1  head entry ready to retire
commit_ready_i  in  1  retire accepted
commit_tag_o  out  ROBsizeLog  tag of head
commit_dest_o  out  DEST_W  head destination
commit_data_o  out  64  head data
commit_flags_o  out  4  head flags
commit_setsFlags_o  out  1  head writes flags
count_o  out  ROBsizeLog  occupied entries

Behaviour:
- State:
  - head and tail indices, 0..ROBsize-1.
  - count, 0..ROBsize.
  - Per entry: busy, dest, setsFlags, data, dataValid, flags, flagsValid.
  - Tag = index+1. Index ROBsize-1 wraps to 0, so tag ROBsize is followed by tag 1.
- Reset (reset_i=0 at the clock edge):
  - head=tail=count=0; all busy/dataValid/flagsValid cleared.
  - Outputs: alloc_ready_o=1, alloc_tag_o=1, commit_valid_o=0, count_o=0, readVal*_o valid bit=0.
- flush_i=1: same register effect as reset at that edge. It takes priority over alloc, write and commit in the same cycle.
- Allocation:
  - alloc_ready_o = (count != ROBsize), combinational.
  - alloc_tag_o = tail+1.
  - On alloc_valid_i & alloc_ready_o: entry[tail] is loaded with busy=1, dest, setsFlags, dataValid=0, flagsValid=0; tail advances.
  - When full, alloc is refused even if a commit occurs in the same cycle.
- Completion write, on ROBWriteEn_i:
  - Ignored if ROBWriteAddr_i==0, if it exceeds ROBsize, or if the target entry is not busy.
  - If bit 64 is set: data and dataValid=1 are written.
  - If bit 69 is set: flags and flagsValid=1 are written.
  - Either valid bit may arrive alone.
  - The write takes effect at the edge; commit sees it no earlier than the next cycle.
- Lookup ports, combinational:
  - readTag 0 or a non-busy entry → valid=0, data=0.
  - Otherwise the entry's data and dataValid are returned.
  - Same-cycle bypass: an enabled completion write with data valid to the same busy tag is forwarded, giving valid=1 and the new data.
- Commit:
  - commit_valid_o = busy[head] & dataValid[head] & (~setsFlags[head] | flagsValid[head]).
  - Commit fields are driven from entry[head].
  - On commit_valid_o & commit_ready_i: busy[head] cleared, head advances with wrap.
- count_o update:
  - +1 on allocation only.
  - -1 on commit only.
  - Unchanged when both or neither happen in a cycle.
- Empty case: commit_valid_o=0, and lookups return invalid.
- Reset has no side effects apart from the register clears listed above.

Decomposition:
- rob_pkg holds:
  - entry struct typedef (busy, dest, setsFlags, data, dataValid, flags, flagsValid);
  - bit-position constants for the 70-bit write word (DATA_LSB=0, DATA_V=64, FLAGS_LSB=65, FLAGS_V=69);
  - the 65-bit value-bus layout.
- Sub-module rob_ptr: a wrapping index register with increment enable and synchronous active-low reset. It is instantiated for head and for tail.

Test Plan:
- Reset, then alloc 3 cycles → tags 1,2,3; count_o=3. Write tag 2 with data 0xAA and bit 64 → no commit (head tag 1 not ready). Write tag 1 → commit_valid_o next cycle, tag 1, then tag 2 with data 0xAA.
- Allocate 32 → alloc_ready_o=0 and a 33rd request is ignored. Commit one, then allocate → granted tag 1 (wrap); count_o=32.
- Head with setsFlags=1: write data only → commit_valid_o stays 0. Write flags 4'b0100 with bit 69 → commit_valid_o=1, commit_flags_o=4'b0100.
- readTagA=5 while a completion writes tag 5 with 0x1234 in the same cycle → readValA_o={1,0x1234}. readTagB=0 → valid=0. Write to tag 0 → no state change.
- Fill 6 entries, complete 3, then assert flush_i together with alloc_valid_i → count_o=0, alloc_tag_o=1, commit_valid_o=0 next cycle.
- Drive reset_i=0 mid-operation with commit_ready_i=1 → all state is cleared at the edge and no commit handshake completes that cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and bit layouts for the reorder buffer: entry record, completion write word
// and the operand value bus handed to the reservation stations.
package rob_pkg;

    localparam int unsigned ROB_DEST_W = 5;

    // Completion write word layout
    localparam int unsigned WR_W      = 70;
    localparam int unsigned DATA_LSB  = 0;
    localparam int unsigned DATA_V    = 64;
    localparam int unsigned FLAGS_LSB = 65;
    localparam int unsigned FLAGS_V   = 69;

    // Operand value bus layout
    localparam int unsigned VAL_W        = 65;
    localparam int unsigned VAL_DATA_LSB = 0;
    localparam int unsigned VAL_V        = 64;

    typedef logic [VAL_W-1:0] rob_val_t;

    typedef struct packed {
        logic                  busy;
        logic [ROB_DEST_W-1:0] dest;
        logic                  sets_flags;
        logic [63:0]           data;
        logic                  data_valid;
        logic [3:0]            flags;
        logic                  flags_valid;
    } rob_entry_t;

    function automatic rob_val_t make_val(input logic valid, input logic [63:0] data);
        return {valid, data};
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping index register for the ROB head/tail: counts 0..Size-1 and wraps back to 0.
module rob_ptr #(
    parameter int unsigned Size = 32,
    localparam int unsigned IdxW = (Size > 1) ? $clog2(Size) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = (idx_q == IdxW'(Size - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at dispatch, tagged completion writes,
// two operand lookup ports with same-cycle bypass, and in-order retirement from the head.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned ROBsize    = 32,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
    parameter int unsigned DEST_W     = ROB_DEST_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    input  logic [DEST_W-1:0]     alloc_dest_i,
    input  logic                  alloc_setsFlags_i,
    output logic                  alloc_ready_o,
    output logic [ROBsizeLog-1:0] alloc_tag_o,
    input  logic                  ROBWriteEn_i,
    input  logic [ROBsizeLog-1:0] ROBWriteAddr_i,
    input  logic [WR_W-1:0]       ROBWriteData_i,
    input  logic [ROBsizeLog-1:0] readTagA_i,
    input  logic [ROBsizeLog-1:0] readTagB_i,
    output logic [VAL_W-1:0]      readValA_o,
    output logic [VAL_W-1:0]      readValB_o,
    output logic                  commit_valid_o,
    input  logic                  commit_ready_i,
    output logic [ROBsizeLog-1:0] commit_tag_o,
    output logic [DEST_W-1:0]     commit_dest_o,
    output logic [63:0]           commit_data_o,
    output logic [3:0]            commit_flags_o,
    output logic                  commit_setsFlags_o,
    output logic [ROBsizeLog-1:0] count_o
);

    localparam int unsigned IdxW = (ROBsize > 1) ? $clog2(ROBsize) : 1;

    // Tags are index+1; tag 0 means "no tag".
    function automatic logic [IdxW-1:0] tag2idx(input logic [ROBsizeLog-1:0] tag);
        logic [ROBsizeLog-1:0] t;
        t = tag - 1'b1;
        return t[IdxW-1:0];
    endfunction

    function automatic logic tag_ok(input logic [ROBsizeLog-1:0] tag);
        return (tag != '0) && (tag <= ROBsizeLog'(ROBsize));
    endfunction

    rob_entry_t entries_q [ROBsize];
    rob_entry_t entries_d [ROBsize];

    logic [ROBsizeLog-1:0] count_q, count_d;
    logic [IdxW-1:0]       head_idx, tail_idx, wr_idx;
    logic                  alloc_fire, commit_fire, wr_hit;
    logic                  wr_data_v, wr_flags_v;
    logic [63:0]           wr_data;
    logic [3:0]            wr_flags;
    rob_entry_t            head_e;

    rob_ptr #(.Size(ROBsize)) u_head (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (commit_fire),
        .idx_o   (head_idx)
    );

    rob_ptr #(.Size(ROBsize)) u_tail (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (alloc_fire),
        .idx_o   (tail_idx)
    );

    assign wr_data    = ROBWriteData_i[DATA_LSB +: 64];
    assign wr_data_v  = ROBWriteData_i[DATA_V];
    assign wr_flags   = ROBWriteData_i[FLAGS_LSB +: 4];
    assign wr_flags_v = ROBWriteData_i[FLAGS_V];
    assign wr_idx     = tag2idx(ROBWriteAddr_i);
    assign wr_hit     = ROBWriteEn_i && tag_ok(ROBWriteAddr_i) && entries_q[wr_idx].busy;

    assign head_e         = entries_q[head_idx];
    assign commit_valid_o = head_e.busy && head_e.data_valid &&
                            (!head_e.sets_flags || head_e.flags_valid);
    // A full buffer refuses allocation even if the head retires this cycle.
    assign alloc_ready_o  = (count_q != ROBsizeLog'(ROBsize));
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;
    assign commit_fire    = commit_valid_o && commit_ready_i;

    assign alloc_tag_o        = ROBsizeLog'(tail_idx) + ROBsizeLog'(1);
    assign commit_tag_o       = ROBsizeLog'(head_idx) + ROBsizeLog'(1);
    assign commit_dest_o      = DEST_W'(head_e.dest);
    assign commit_data_o      = head_e.data;
    assign commit_flags_o     = head_e.flags;
    assign commit_setsFlags_o = head_e.sets_flags;
    assign count_o            = count_q;

    logic [ROBsizeLog-1:0] rd_tag [2];
    rob_val_t              rd_val [2];

    assign rd_tag[0]  = readTagA_i;
    assign rd_tag[1]  = readTagB_i;
    assign readValA_o = rd_val[0];
    assign readValB_o = rd_val[1];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic [IdxW-1:0] idx;
            idx       = tag2idx(rd_tag[p]);
            rd_val[p] = '0;
            if (tag_ok(rd_tag[p]) && entries_q[idx].busy) begin
                if (wr_hit && wr_data_v && (ROBWriteAddr_i == rd_tag[p])) begin
                    rd_val[p] = make_val(1'b1, wr_data);
                end else begin
                    rd_val[p] = make_val(entries_q[idx].data_valid, entries_q[idx].data);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROBsize; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (wr_hit) begin
            if (wr_data_v) begin
                entries_d[wr_idx].data       = wr_data;
                entries_d[wr_idx].data_valid = 1'b1;
            end
            if (wr_flags_v) begin
                entries_d[wr_idx].flags       = wr_flags;
                entries_d[wr_idx].flags_valid = 1'b1;
            end
        end
        if (commit_fire) begin
            entries_d[head_idx].busy = 1'b0;
        end
        // The tail slot is never busy when allocation fires, so no write can collide with it.
        if (alloc_fire) begin
            entries_d[tail_idx].busy        = 1'b1;
            entries_d[tail_idx].dest        = ROB_DEST_W'(alloc_dest_i);
            entries_d[tail_idx].sets_flags  = alloc_setsFlags_i;
            entries_d[tail_idx].data_valid  = 1'b0;
            entries_d[tail_idx].flags_valid = 1'b0;
        end
        if (flush_i) begin
            for (int i = 0; i < ROBsize; i++) begin
                entries_d[i].busy        = 1'b0;
                entries_d[i].data_valid  = 1'b0;
                entries_d[i].flags_valid = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (alloc_fire && !commit_fire) begin
            count_d = count_q + 1'b1;
        end else if (commit_fire && !alloc_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q <= '0;
            for (int i = 0; i < ROBsize; i++) begin
                entries_q[i].busy        <= 1'b0;
                entries_q[i].data_valid  <= 1'b0;
                entries_q[i].flags_valid <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < ROBsize; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; retirements are checked by a scoreboard monitor.
module tb_reorder_buffer;

    localparam int unsigned N  = 32;
    localparam int unsigned TW = 6;

    logic          clk = 1'b0;
    logic          reset_i, flush_i, alloc_valid_i, alloc_setsFlags_i, alloc_ready_o;
    logic [4:0]    alloc_dest_i, commit_dest_o;
    logic [TW-1:0] alloc_tag_o, ROBWriteAddr_i, readTagA_i, readTagB_i, commit_tag_o, count_o;
    logic          ROBWriteEn_i, commit_valid_o, commit_ready_i, commit_setsFlags_o;
    logic [69:0]   ROBWriteData_i;
    logic [64:0]   readValA_o, readValB_o;
    logic [63:0]   commit_data_o;
    logic [3:0]    commit_flags_o;

    typedef struct {
        logic [TW-1:0] tag;
        logic [4:0]    dest;
        logic [63:0]   data;
        logic [3:0]    flags;
        logic          sf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reorder_buffer #(.ROBsize(N)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .flush_i            (flush_i),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_dest_i       (alloc_dest_i),
        .alloc_setsFlags_i  (alloc_setsFlags_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_tag_o        (alloc_tag_o),
        .ROBWriteEn_i       (ROBWriteEn_i),
        .ROBWriteAddr_i     (ROBWriteAddr_i),
        .ROBWriteData_i     (ROBWriteData_i),
        .readTagA_i         (readTagA_i),
        .readTagB_i         (readTagB_i),
        .readValA_o         (readValA_o),
        .readValB_o         (readValB_o),
        .commit_valid_o     (commit_valid_o),
        .commit_ready_i     (commit_ready_i),
        .commit_tag_o       (commit_tag_o),
        .commit_dest_o      (commit_dest_o),
        .commit_data_o      (commit_data_o),
        .commit_flags_o     (commit_flags_o),
        .commit_setsFlags_o (commit_setsFlags_o),
        .count_o            (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wr(input logic [TW-1:0] tag, input logic [63:0] d, input logic dv,
                      input logic [3:0] f, input logic fv);
        ROBWriteEn_i   = 1'b1;
        ROBWriteAddr_i = tag;
        ROBWriteData_i = {fv, f, dv, d};
    endtask

    task automatic flush();
        flush_i = 1'b1;
        edge_();
        flush_i = 1'b0;
    endtask

    task automatic alloc_n(input int n, input logic sf);
        alloc_valid_i     = 1'b1;
        alloc_setsFlags_i = sf;
        for (int i = 0; i < n; i++) begin
            alloc_dest_i = 5'(i);
            edge_();
        end
        alloc_valid_i     = 1'b0;
        alloc_setsFlags_i = 1'b0;
    endtask

    // Scoreboard monitor: every completed retire handshake must match the next expectation.
    always @(negedge clk) begin
        if (reset_i && !flush_i && commit_valid_o && commit_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got tag %0d expected none", commit_tag_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_tag", 70'(commit_tag_o), 70'(e.tag));
                chk("commit_dest", 70'(commit_dest_o), 70'(e.dest));
                chk("commit_data", 70'(commit_data_o), 70'(e.data));
                chk("commit_sets_flags", 70'(commit_setsFlags_o), 70'(e.sf));
                if (e.sf) chk("commit_flags", 70'(commit_flags_o), 70'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_dest_i = '0;
        alloc_setsFlags_i = 1'b0; ROBWriteEn_i = 1'b0; ROBWriteAddr_i = '0;
        ROBWriteData_i = '0; readTagA_i = 6'd1; readTagB_i = '0; commit_ready_i = 1'b0;
        edge_();
        edge_();
        settle();
        chk("rst_alloc_ready", 70'(alloc_ready_o), 70'd1);
        chk("rst_alloc_tag", 70'(alloc_tag_o), 70'd1);
        chk("rst_commit_valid", 70'(commit_valid_o), 70'd0);
        chk("rst_count", 70'(count_o), 70'd0);
        chk("rst_readA_valid", 70'(readValA_o[64]), 70'd0);
        edge_();
        reset_i = 1'b1;

        // In-order retirement with out-of-order completion
        alloc_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alloc_dest_i = 5'(i + 4);
            settle();
            chk("alloc_tag_seq", 70'(alloc_tag_o), 70'(i));
            edge_();
        end
        alloc_valid_i = 1'b0;
        settle();
        chk("count_after_3", 70'(count_o), 70'd3);
        edge_();
        wr(6'd2, 64'hAA, 1'b1, 4'h0, 1'b0);
        edge_();
        wr(6'd1, 64'h11, 1'b1, 4'h0, 1'b0);
        settle();
        chk("no_commit_head_unready", 70'(commit_valid_o), 70'd0);
        edge_();
        ROBWriteEn_i = 1'b0;
        sb.push_back('{tag: 6'd1, dest: 5'd5, data: 64'h11, flags: 4'h0, sf: 1'b0});
        sb.push_back('{tag: 6'd2, dest: 5'd6, data: 64'hAA, flags: 4'h0, sf: 1'b0});
        commit_ready_i = 1'b1;
        settle();
        chk("commit_valid_tag1", 70'(commit_valid_o), 70'd1);
        edge_();
        edge_();
        commit_ready_i = 1'b0;
        settle();
        chk("count_after_2_commits", 70'(count_o), 70'd1);
        chk("head_tag3_not_ready", 70'(commit_valid_o), 70'd0);
        edge_();

        // Fill to capacity, refuse when full, then wrap the tail
        flush();
        alloc_n(32, 1'b0);
        settle();
        chk("full_alloc_ready", 70'(alloc_ready_o), 70'd0);
        chk("full_count", 70'(count_o), 70'd32);
        edge_();
        alloc_valid_i = 1'b1;
        edge_();
        alloc_valid_i = 1'b0;
        settle();
        chk("full_33rd_ignored", 70'(count_o), 70'd32);
        edge_();
        wr(6'd1, 64'h5, 1'b1, 4'h0, 1'b0);
        edge_();
        ROBWriteEn_i = 1'b0;
        sb.push_back('{tag: 6'd1, dest: 5'd0, data: 64'h5, flags: 4'h0, sf: 1'b0});
        commit_ready_i = 1'b1;
        alloc_valid_i  = 1'b1;
        alloc_dest_i   = 5'd17;
        edge_();
        commit_ready_i = 1'b0;
        settle();
        chk("full_commit_alloc_refused", 70'(count_o), 70'd31);
        chk("wrap_alloc_tag", 70'(alloc_tag_o), 70'd1);
        edge_();
        alloc_valid_i = 1'b0;
        settle();
        chk("wrap_count", 70'(count_o), 70'd32);
        chk("wrap_next_tag", 70'(alloc_tag_o), 70'd2);
        edge_();

        // Flag-setting head waits for its flags
        flush();
        alloc_valid_i     = 1'b1;
        alloc_setsFlags_i = 1'b1;
        alloc_dest_i      = 5'd3;
        edge_();
        alloc_valid_i     = 1'b0;
        alloc_setsFlags_i = 1'b0;
        wr(6'd1, 64'h77, 1'b1, 4'h0, 1'b0);
        edge_();
        ROBWriteEn_i = 1'b0;
        settle();
        chk("flags_pending_no_commit", 70'(commit_valid_o), 70'd0);
        edge_();
        wr(6'd1, 64'h0, 1'b0, 4'b0100, 1'b1);
        edge_();
        ROBWriteEn_i = 1'b0;
        sb.push_back('{tag: 6'd1, dest: 5'd3, data: 64'h77, flags: 4'b0100, sf: 1'b1});
        commit_ready_i = 1'b1;
        settle();
        chk("flags_commit_valid", 70'(commit_valid_o), 70'd1);
        chk("flags_value", 70'(commit_flags_o), 70'b0100);
        edge_();
        commit_ready_i = 1'b0;
        settle();
        chk("flags_count_after", 70'(count_o), 70'd0);
        edge_();

        // Lookup bypass and ignored writes
        flush();
        alloc_n(5, 1'b0);
        readTagA_i = 6'd5;
        readTagB_i = 6'd0;
        wr(6'd5, 64'h1234, 1'b1, 4'h0, 1'b0);
        settle();
        chk("bypass_readA", 70'(readValA_o), {5'd0, 1'b1, 64'h1234});
        chk("tag0_readB", 70'(readValB_o), 70'd0);
        edge_();
        ROBWriteEn_i = 1'b0;
        settle();
        chk("stored_readA", 70'(readValA_o), {5'd0, 1'b1, 64'h1234});
        edge_();
        wr(6'd0, 64'h9999, 1'b1, 4'h0, 1'b0);
        edge_();
        wr(6'd33, 64'h8888, 1'b1, 4'h0, 1'b0);
        edge_();
        ROBWriteEn_i = 1'b0;
        readTagA_i   = 6'd1;
        settle();
        chk("ignored_writes_tag1", 70'(readValA_o[64]), 70'd0);
        chk("ignored_writes_commit", 70'(commit_valid_o), 70'd0);
        chk("ignored_writes_count", 70'(count_o), 70'd5);
        edge_();

        // Flush beats a simultaneous allocation
        flush();
        alloc_n(6, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            wr(6'(i), 64'(i * 16), 1'b1, 4'h0, 1'b0);
            edge_();
        end
        ROBWriteEn_i  = 1'b0;
        flush_i       = 1'b1;
        alloc_valid_i = 1'b1;
        edge_();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        settle();
        chk("flush_count", 70'(count_o), 70'd0);
        chk("flush_alloc_tag", 70'(alloc_tag_o), 70'd1);
        chk("flush_commit_valid", 70'(commit_valid_o), 70'd0);
        edge_();

        // Reset mid-operation with a pending retire
        alloc_n(2, 1'b0);
        wr(6'd1, 64'hBEEF, 1'b1, 4'h0, 1'b0);
        edge_();
        ROBWriteEn_i = 1'b0;
        settle();
        chk("pre_reset_commit_valid", 70'(commit_valid_o), 70'd1);
        reset_i        = 1'b0;
        commit_ready_i = 1'b1;
        edge_();
        reset_i        = 1'b1;
        commit_ready_i = 1'b0;
        settle();
        chk("mid_reset_count", 70'(count_o), 70'd0);
        chk("mid_reset_commit_valid", 70'(commit_valid_o), 70'd0);
        chk("mid_reset_alloc_tag", 70'(alloc_tag_o), 70'd1);
        chk("mid_reset_readA", 70'(readValA_o[64]), 70'd0);
        chk("scoreboard_drained", 70'(sb.size()), 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
